// File: rtl/dxl_pkg.sv
// Shared definitions for the Dynamixel half-duplex bus: framing constants,
// default timing, FSM state types and the status checksum helper.
package dxl_pkg;

    localparam logic [7:0] DXL_HDR            = 8'hFF;
    localparam int         DXL_CLKS_PER_BIT   = 876;
    localparam int         DXL_MAX_PARAMS     = 4;
    localparam int         DXL_TIMEOUT_CYCLES = 175200;

    typedef enum logic [3:0] {
        PS_IDLE  = 4'd0,
        PS_HDR1  = 4'd1,
        PS_HDR2  = 4'd2,
        PS_ID    = 4'd3,
        PS_LEN   = 4'd4,
        PS_ERR   = 4'd5,
        PS_PARAM = 4'd6,
        PS_CSUM  = 4'd7,
        PS_DONE  = 4'd8
    } parse_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Checksum byte expected for a given running sum of ID..last param.
    function automatic logic [7:0] dxl_csum(input logic [7:0] sum);
        return ~sum;
    endfunction

endpackage

// File: rtl/dxl_uart_rx_byte.sv
// Synchroniser plus 8N1 byte receiver. Runs continuously; emits one-cycle
// byte_valid_o with the data byte and a stop-bit error flag.
module dxl_uart_rx_byte
    import dxl_pkg::*;
#(
    parameter int CLKS_PER_BIT = DXL_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       stop_err_o
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    logic            sync1_q;
    logic            sync2_q;
    logic            prev_q;
    rx_state_e       state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            byte_valid_q;
    logic [7:0]      byte_data_q;
    logic            stop_err_q;

    // Synchroniser, edge detect and bit-timing state machine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            prev_q       <= 1'b1;
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= 3'd0;
            shift_q      <= 8'd0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'd0;
            stop_err_q   <= 1'b0;
        end else begin
            sync1_q      <= rxd_i;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            byte_valid_q <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    bit_q <= 3'd0;
                    if (prev_q && !sync2_q) begin
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    // A line that is high again at mid start bit was a glitch.
                    if (cnt_q == CW'(HALF - 1)) begin
                        cnt_q   <= '0;
                        state_q <= sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        shift_q <= {sync2_q, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                        cnt_q        <= '0;
                        byte_valid_q <= 1'b1;
                        byte_data_q  <= shift_q;
                        stop_err_q   <= ~sync2_q;
                        state_q      <= RX_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= RX_IDLE;
                end
            endcase
        end
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_data_o  = byte_data_q;
    assign stop_err_o   = stop_err_q;

endmodule

// File: rtl/dxl_status_rx.sv
// Dynamixel status packet receiver: parses FF FF ID LEN ERR P0..Pn CSUM from
// the serial line after arm and reports fields plus error flags on a strobe.
module dxl_status_rx
    import dxl_pkg::*;
#(
    parameter int CLKS_PER_BIT   = DXL_CLKS_PER_BIT,
    parameter int MAX_PARAMS     = DXL_MAX_PARAMS,
    parameter int TIMEOUT_CYCLES = DXL_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rxd,
    input  logic                    arm,
    output logic                    busy,
    output logic                    result_valid,
    output logic [7:0]              status_id,
    output logic [7:0]              status_err,
    output logic [2:0]              param_cnt,
    output logic [8*MAX_PARAMS-1:0] params,
    output logic                    csum_fail,
    output logic                    len_fail,
    output logic                    frame_fail,
    output logic                    timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic       byte_valid_s;
    logic [7:0] byte_data_s;
    logic       stop_err_s;

    parse_state_e            state_q;
    logic [TW-1:0]           tmo_cnt_q;
    logic [7:0]              sum_q;
    logic [2:0]              k_q;
    logic                    busy_q;
    logic                    result_valid_q;
    logic [7:0]              status_id_q;
    logic [7:0]              status_err_q;
    logic [2:0]              param_cnt_q;
    logic [8*MAX_PARAMS-1:0] params_q;
    logic                    csum_fail_q;
    logic                    len_fail_q;
    logic                    frame_fail_q;
    logic                    timeout_q;

    dxl_uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_byte (
        .clk          (clk),
        .reset        (reset),
        .rxd_i        (rxd),
        .byte_valid_o (byte_valid_s),
        .byte_data_o  (byte_data_s),
        .stop_err_o   (stop_err_s)
    );

    // Packet parser with timeout; arm has priority over any received byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= PS_IDLE;
            tmo_cnt_q      <= '0;
            sum_q          <= 8'd0;
            k_q            <= 3'd0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            status_id_q    <= 8'd0;
            status_err_q   <= 8'd0;
            param_cnt_q    <= 3'd0;
            params_q       <= '0;
            csum_fail_q    <= 1'b0;
            len_fail_q     <= 1'b0;
            frame_fail_q   <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            if (arm) begin
                state_q      <= PS_HDR1;
                tmo_cnt_q    <= '0;
                sum_q        <= 8'd0;
                k_q          <= 3'd0;
                busy_q       <= 1'b1;
                status_id_q  <= 8'd0;
                status_err_q <= 8'd0;
                param_cnt_q  <= 3'd0;
                params_q     <= '0;
                csum_fail_q  <= 1'b0;
                len_fail_q   <= 1'b0;
                frame_fail_q <= 1'b0;
                timeout_q    <= 1'b0;
            end else begin
                case (state_q)
                    PS_IDLE: begin
                        tmo_cnt_q <= '0;
                    end
                    PS_DONE: begin
                        result_valid_q <= 1'b1;
                        busy_q         <= 1'b0;
                        state_q        <= PS_IDLE;
                    end
                    PS_HDR1, PS_HDR2, PS_ID, PS_LEN, PS_ERR, PS_PARAM, PS_CSUM: begin
                        if (byte_valid_s) begin
                            tmo_cnt_q <= '0;
                            if (stop_err_s) begin
                                frame_fail_q <= 1'b1;
                            end
                            case (state_q)
                                PS_HDR1: begin
                                    if (byte_data_s == DXL_HDR) begin
                                        state_q <= PS_HDR2;
                                    end
                                end
                                PS_HDR2: begin
                                    state_q <= (byte_data_s == DXL_HDR) ? PS_ID : PS_HDR1;
                                end
                                PS_ID: begin
                                    // Extra 0xFF preamble bytes are tolerated here.
                                    if (byte_data_s != DXL_HDR) begin
                                        status_id_q <= byte_data_s;
                                        sum_q       <= byte_data_s;
                                        state_q     <= PS_LEN;
                                    end
                                end
                                PS_LEN: begin
                                    sum_q <= sum_q + byte_data_s;
                                    if ((byte_data_s < 8'd2) ||
                                        (byte_data_s > 8'(MAX_PARAMS + 2))) begin
                                        len_fail_q <= 1'b1;
                                        state_q    <= PS_DONE;
                                    end else begin
                                        param_cnt_q <= 3'(byte_data_s - 8'd2);
                                        state_q     <= PS_ERR;
                                    end
                                end
                                PS_ERR: begin
                                    status_err_q <= byte_data_s;
                                    sum_q        <= sum_q + byte_data_s;
                                    k_q          <= 3'd0;
                                    state_q      <= (param_cnt_q == 3'd0) ? PS_CSUM : PS_PARAM;
                                end
                                PS_PARAM: begin
                                    sum_q <= sum_q + byte_data_s;
                                    for (int i = 0; i < MAX_PARAMS; i++) begin
                                        if (k_q == 3'(i)) begin
                                            params_q[8*i +: 8] <= byte_data_s;
                                        end
                                    end
                                    if (k_q == (param_cnt_q - 3'd1)) begin
                                        state_q <= PS_CSUM;
                                    end else begin
                                        k_q <= k_q + 3'd1;
                                    end
                                end
                                PS_CSUM: begin
                                    csum_fail_q <= (byte_data_s != dxl_csum(sum_q));
                                    state_q     <= PS_DONE;
                                end
                                default: begin
                                    state_q <= PS_IDLE;
                                end
                            endcase
                        end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                            timeout_q <= 1'b1;
                            state_q   <= PS_DONE;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + TW'(1);
                        end
                    end
                    default: begin
                        state_q <= PS_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign status_id    = status_id_q;
    assign status_err   = status_err_q;
    assign param_cnt    = param_cnt_q;
    assign params       = params_q;
    assign csum_fail    = csum_fail_q;
    assign len_fail     = len_fail_q;
    assign frame_fail   = frame_fail_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_dxl_status_rx.sv
// Directed bench for dxl_status_rx: drives 8N1 frames on rxd with a short bit
// time and compares result fields against hand-computed values.
module tb_dxl_status_rx;

    localparam int C  = 16;
    localparam int T  = 400;
    localparam int MP = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          rxd;
    logic          arm;
    logic          busy;
    logic          result_valid;
    logic [7:0]    status_id;
    logic [7:0]    status_err;
    logic [2:0]    param_cnt;
    logic [31:0]   params;
    logic          csum_fail;
    logic          len_fail;
    logic          frame_fail;
    logic          timeout;

    int n_checks = 0;
    int n_pass   = 0;
    int strobe_cnt = 0;
    int strobe_cyc = 0;
    int cyc = 0;
    logic [7:0] tx_q[$];

    dxl_status_rx #(
        .CLKS_PER_BIT   (C),
        .MAX_PARAMS     (MP),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rxd          (rxd),
        .arm          (arm),
        .busy         (busy),
        .result_valid (result_valid),
        .status_id    (status_id),
        .status_err   (status_err),
        .param_cnt    (param_cnt),
        .params       (params),
        .csum_fail    (csum_fail),
        .len_fail     (len_fail),
        .frame_fail   (frame_fail),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (result_valid) begin
            strobe_cnt = strobe_cnt + 1;
            strobe_cyc = cyc;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (C) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (C) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic send_q();
        while (tx_q.size() > 0) begin
            send_byte(tx_q.pop_front(), 1'b1);
        end
    endtask

    task automatic do_arm();
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic wait_strobe(input int prev, input int budget, input string tag);
        int n;
        n = 0;
        while (strobe_cnt == prev && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, strobe_cnt - prev, 1);
    endtask

    task automatic check_res(input string tag, input logic [7:0] id, input logic [7:0] err,
                             input logic [2:0] cnt, input logic [31:0] prm,
                             input logic [3:0] flags);
        check_val({tag, ".id"}, status_id, id);
        check_val({tag, ".err"}, status_err, err);
        check_val({tag, ".cnt"}, param_cnt, cnt);
        check_val({tag, ".params"}, params, prm);
        check_val({tag, ".flags"}, {csum_fail, len_fail, frame_fail, timeout}, flags);
        check_val({tag, ".busy"}, busy, 1'b0);
    endtask

    initial begin
        int pre;
        int t_end;
        reset = 1'b1;
        rxd   = 1'b1;
        arm   = 1'b0;
        repeat (5) @(negedge clk);
        check_val("rst.outs", {busy, result_valid, status_id, status_err, param_cnt,
                               csum_fail, len_fail, frame_fail, timeout}, 32'd0);
        check_val("rst.params", params, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Valid packet with two parameters.
        do_arm();
        check_val("s1.busy_arm", busy, 1'b1);
        pre = strobe_cnt;
        tx_q = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h20, 8'h02, 8'hD8};
        send_q();
        wait_strobe(pre, 4 * C, "s1.strobe");
        check_res("s1", 8'h01, 8'h00, 3'd2, 32'h0000_0220, 4'b0000);
        repeat (2 * C) @(negedge clk);

        // Leading garbage and an extra preamble byte, no parameters.
        do_arm();
        pre = strobe_cnt;
        tx_q = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00, 8'hFC};
        send_q();
        wait_strobe(pre, 4 * C, "s2.strobe");
        check_res("s2", 8'h01, 8'h00, 3'd0, 32'd0, 4'b0000);
        repeat (2 * C) @(negedge clk);

        // Bad checksum.
        do_arm();
        pre = strobe_cnt;
        tx_q = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h20, 8'h02, 8'hD7};
        send_q();
        wait_strobe(pre, 4 * C, "s3.strobe");
        check_res("s3", 8'h01, 8'h00, 3'd2, 32'h0000_0220, 4'b1000);
        repeat (2 * C) @(negedge clk);

        // Out-of-range LEN ends the packet at the LEN byte.
        do_arm();
        pre = strobe_cnt;
        tx_q = '{8'hFF, 8'hFF, 8'h01, 8'h09};
        send_q();
        wait_strobe(pre, 4 * C, "s4.strobe");
        check_res("s4", 8'h01, 8'h00, 3'd0, 32'd0, 4'b0100);
        tx_q = '{8'h00, 8'hF6};
        send_q();
        repeat (2 * C) @(negedge clk);
        check_val("s4.no_more_strobe", strobe_cnt - pre, 1);
        check_val("s4.busy_after", busy, 1'b0);

        // Timeout after the ID byte.
        do_arm();
        pre = strobe_cnt;
        tx_q = '{8'hFF, 8'hFF, 8'h01};
        send_q();
        t_end = cyc;
        wait_strobe(pre, T + 8 * C, "s5.strobe");
        check_res("s5", 8'h01, 8'h00, 3'd0, 32'd0, 4'b0001);
        check_val("s5.delay_ok",
                  ((strobe_cyc - t_end) >= (T - 5)) && ((strobe_cyc - t_end) <= (T - 1)), 1'b1);
        repeat (2 * C) @(negedge clk);

        // Stop bit low on the ID byte; idle gap lets the next start edge be seen.
        do_arm();
        pre = strobe_cnt;
        send_byte(8'hFF, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h01, 1'b0);
        repeat (C) @(negedge clk);
        tx_q = '{8'h02, 8'h00, 8'hFC};
        send_q();
        wait_strobe(pre, 4 * C, "s6.strobe");
        check_res("s6", 8'h01, 8'h00, 3'd0, 32'd0, 4'b0010);
        repeat (2 * C) @(negedge clk);

        // Re-arm mid-packet aborts the first packet silently.
        do_arm();
        pre = strobe_cnt;
        tx_q = '{8'hFF, 8'hFF, 8'h01, 8'h04};
        send_q();
        do_arm();
        check_val("s7.cleared", {status_id, 5'd0, param_cnt}, 16'd0);
        check_val("s7.busy_rearm", busy, 1'b1);
        check_val("s7.no_strobe", strobe_cnt - pre, 0);
        tx_q = '{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h20, 8'h02, 8'hD8};
        send_q();
        wait_strobe(pre, 4 * C, "s7.strobe");
        check_res("s7", 8'h01, 8'h00, 3'd2, 32'h0000_0220, 4'b0000);
        repeat (2 * C) @(negedge clk);

        // Reset in the middle of a byte.
        do_arm();
        pre = strobe_cnt;
        tx_q = '{8'hFF, 8'hFF, 8'h01, 8'h04};
        send_q();
        rxd = 1'b0;
        repeat (3 * C) @(negedge clk);
        reset = 1'b1;
        #2;
        check_val("s8.outs", {busy, result_valid, status_id, status_err, param_cnt,
                              csum_fail, len_fail, frame_fail, timeout}, 32'd0);
        check_val("s8.params", params, 32'd0);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2 * C) @(negedge clk);
        check_val("s8.no_strobe", strobe_cnt - pre, 0);

        // Recovery after reset.
        do_arm();
        pre = strobe_cnt;
        tx_q = '{8'hFF, 8'hFF, 8'h05, 8'h02, 8'h01, 8'hF7};
        send_q();
        wait_strobe(pre, 4 * C, "s9.strobe");
        check_res("s9", 8'h05, 8'h01, 3'd0, 32'd0, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dxl_status_rx.md
Name: dxl_status_rx

Overview:
- Receive path for the Dynamixel half-duplex bus.
- Consumes the raw RXD line after the instruction transmitter has released the bus, and deserialises 8N1 bytes.
- Parses the status packet: FF FF ID LEN ERR P0..Pn CSUM.
- Presents validated fields plus error flags to the NIOS-facing register layer as a single-cycle result strobe.

Parameters:
- CLKS_PER_BIT, 876: clk cycles per bit. 50 MHz / 876 ≈ 57.08 kbaud, matching the instruction transmitter.
- MAX_PARAMS, 4: maximum status parameters stored. Legal LEN range is 2..MAX_PARAMS+2.
- TIMEOUT_CYCLES, 175200: idle clk cycles (≈200 bit times) allowed after arm or after the last received byte before the packet is aborted.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- rxd  in  1  raw serial line, asynchronous to clk, idle high
- arm  in  1  single-cycle pulse; transmitter finished, start listening
- busy  out  1  high from arm until result
- result_valid  out  1  single-cycle strobe; all result fields valid and held until next arm
- status_id  out  8  received ID
- status_err  out  8  Dynamixel error byte
- param_cnt  out  3  number of params received (LEN-2)
- params  out  32  param i at bits [8i+7:8i], unused bytes zero
- csum_fail  out  1  checksum mismatch
- len_fail  out  1  LEN<2 or LEN>MAX_PARAMS+2
- frame_fail  out  1  stop bit sampled low in some byte
- timeout  out  1  TIMEOUT_CYCLES elapsed without completion

Behaviour:
- Reset: all outputs 0; parser in IDLE; byte receiver idle; timeout counter 0.
- rxd passes through a 2-flop synchroniser, which adds 2 cycles of latency. The byte receiver acts only on the synchronised signal.
- Byte receiver states: IDLE, START, DATA, STOP.
  - IDLE: wait for a falling edge.
  - START: sample at CLKS_PER_BIT/2. If the line is high, treat the edge as a glitch and return to IDLE.
  - DATA: sample 8 bits, each CLKS_PER_BIT apart, LSB first.
  - STOP: sample the stop bit. Emit byte_valid for 1 cycle with data, and stop_err = ~stop_bit.
  - The byte receiver runs continuously; the parser ignores bytes while in IDLE.
- Parser FSM states: IDLE, HDR1, HDR2, ID, LEN, ERR, PARAM, CSUM, DONE.
  - IDLE: on arm, clear all result fields and flags, set busy=1, go to HDR1.
  - HDR1: byte 0xFF → HDR2; any other byte stays in HDR1 (leading echo/garbage discarded).
  - HDR2: 0xFF → ID; any other byte → HDR1.
  - ID: 0xFF stays in ID (extra preamble tolerated; status ID is never 0xFF); otherwise latch status_id → LEN.
  - LEN:
    - Latch LEN.
    - If LEN out of range: len_fail=1, go to DONE immediately.
    - Otherwise param_cnt = LEN-2 → ERR.
  - ERR: latch status_err. If param_cnt==0 → CSUM, else → PARAM.
  - PARAM: store byte at index k, starting at k=0. After param_cnt bytes → CSUM.
  - CSUM:
    - Compare received byte with the expected value; csum_fail = (byte != expected).
    - Expected value: ~(ID+LEN+ERR+ΣPi) truncated to 8 bits. The 8-bit running sum accumulates from the ID byte onward and wraps modulo 256.
    - Then → DONE.
  - DONE: result_valid=1 for one cycle, busy=0, → IDLE.
- frame_fail is sticky during a packet. Any stop_err on a byte the parser consumes sets it; parsing continues.
- Timeout:
  - The counter is cleared on arm and on every byte_valid while busy, and increments every cycle while busy.
  - On reaching TIMEOUT_CYCLES-1: timeout=1, → DONE. Partial fields are kept.
- arm while busy: abort the current packet, clear fields, restart at HDR1. No result_valid is emitted for the aborted packet.
- Simultaneous arm and byte_valid: arm wins and the byte is discarded.
- Simultaneous final CSUM byte and timeout expiry: the byte wins and timeout=0.
- Reset mid-packet: immediate return to reset state; no result_valid.
- Latency: result_valid is asserted 2 clk cycles after the CSUM byte's byte_valid.

Decomposition:
- Package dxl_pkg:
  - parser state typedef.
  - DXL_HDR=8'hFF.
  - Default CLKS_PER_BIT and timeout constants, shared with the transmitter.
- Sub-module dxl_uart_rx_byte: synchroniser plus 8N1 byte receiver. Outputs byte_valid, byte_data[7:0], stop_err.

Test Plan:
- arm, then send FF FF 01 04 00 20 02 D8 → result_valid with status_id=01, status_err=00, param_cnt=2, params=32'h0000_0220, all fail flags 0, busy low after the strobe.
- arm, then send 00 FF FF FF 01 02 00 FC (leading garbage plus extra FF) → status_id=01, param_cnt=0, params=0, csum_fail=0.
- arm, then send FF FF 01 04 00 20 02 D7 → csum_fail=1, fields as in scenario 1.
- arm, then send FF FF 01 09 → len_fail=1 and result_valid at the LEN byte; later bytes ignored (busy=0).
- arm, then send only FF FF 01 and go idle → timeout=1 exactly TIMEOUT_CYCLES after the ID byte's byte_valid, status_id=01.
- arm, then send a byte with stop bit forced low inside a valid packet → frame_fail=1. Separately: arm again mid-packet → no result_valid for the first packet; the second packet parses cleanly. Separately: assert reset mid-byte → all outputs 0.
